ifu_fill_ctrl: RTL and testbench
================================

# ifu_fill_ctrl

Miss-handling controller for the IFU instruction cache. It sequences the tag/data arrays, the PLRU tree and the instruction-memory fill port. On each fetch it reports a hit, or it stalls the PC, issues a line fill, writes the victim way and replays the fetch. It sits between the core fetch stage, the cache arrays and `i_mem`, and it is the only writer of the data and tag arrays.

## Interface
- WAYS_NUM, 16, cache ways; the way index is $clog2(WAYS_NUM) bits wide
- CL_WIDTH, 128, cache line width in bits
- TAG_ADDRESS_WIDTH, 28, tag width (pc[31:4])
- FILL_TIMEOUT, 64, cycles to wait for a fill response before re-issuing the request
- CNT_WIDTH, 16, width of the statistics counters

- Clk  in  1  clock; one clock domain
- Rst  in  1  synchronous, active-high reset
- CoreReqValid  in  1  fetch request valid
- CoreReqPc  in  32  fetch PC
- TagHit  in  1  tag compare hit for CoreReqPc (combinational, same cycle)
- TagHitWay  in  $clog2(WAYS_NUM)  hitting way
- PlruVictimWay  in  $clog2(WAYS_NUM)  current PLRU victim
- CoreRspValid  out  1  fetch data valid this cycle (hit)
- StallPc  out  1  hold the PC
- FillReqValid  out  1  fill request to i_mem
- FillReqAddr  out  32  line-aligned address {tag, 4'b0}
- FillReqReady  in  1  i_mem accepts the request
- FillRspValid  in  1  fill response valid
- FillRspAddr  in  32  response address
- FillRspData  in  CL_WIDTH  response line
- ArrWrEn  out  1  write the tag and data arrays
- ArrWrWay  out  $clog2(WAYS_NUM)  way to write
- ArrWrTag  out  TAG_ADDRESS_WIDTH  tag to write
- ArrWrData  out  CL_WIDTH  line to write
- PlruUpdate  out  1  update the PLRU tree
- PlruWay  out  $clog2(WAYS_NUM)  accessed way
- PlruMiss  out  1  the update is for a fill
- MissCount  out  CNT_WIDTH  saturating miss counter
- RetryCount  out  CNT_WIDTH  saturating timeout-retry counter

## Operation
- States: IDLE, SEND_REQ, WAIT_FOR_IMEM, FILL_DATA_ARR, REPLAY.
- IDLE, CoreReqValid & TagHit:
  - CoreRspValid=1 and StallPc=0, combinationally.
  - PlruUpdate=1, PlruWay=TagHitWay, PlruMiss=0.
  - Stay in IDLE.
- IDLE, CoreReqValid & !TagHit:
  - StallPc=1 combinationally.
  - Latch tag=CoreReqPc[31:4] and victim=PlruVictimWay.
  - MissCount++ (saturating); go to SEND_REQ.
- SEND_REQ: FillReqValid=1 and FillReqAddr={tag,4'b0}, held stable until FillReqReady. On ready, clear the timer and go to WAIT_FOR_IMEM.
- WAIT_FOR_IMEM:
  - On FillRspValid & FillRspAddr[31:4]==tag: latch FillRspData and go to FILL_DATA_ARR.
  - Ignore a response whose address does not match.
  - The timer increments each cycle. When it reaches FILL_TIMEOUT-1 with no matching response: RetryCount++ and go to SEND_REQ.
  - A matching response in the timeout cycle wins; no retry.
- FILL_DATA_ARR, one cycle:
  - ArrWrEn=1, ArrWrWay=victim, ArrWrTag=tag, ArrWrData=latched line.
  - PlruUpdate=1, PlruWay=victim, PlruMiss=1.
  - Go to REPLAY.
- REPLAY, one cycle: go to IDLE. The core's held request then hits.
- StallPc=1 in every state except IDLE.
- CoreRspValid=0 outside IDLE.
- A fill is never cancelled; dropping CoreReqValid mid-miss does not abort it.
- FillRspValid outside WAIT_FOR_IMEM is ignored.
- Counters saturate at all-ones and do not wrap.

## Timing
- Reset: state=IDLE. All outputs are 0: CoreRspValid, StallPc, FillReqValid, FillReqAddr, ArrWrEn, ArrWrWay, ArrWrTag, ArrWrData, PlruUpdate, PlruWay, PlruMiss, MissCount, RetryCount. Latched tag, victim, line and timer are 0.
- Reset mid-miss abandons the fill with no ArrWrEn. A stale response arriving later in IDLE is ignored.
- Hit: zero-cycle response, same cycle as the request.
- Miss detected in cycle 0 → FillReqValid in cycle 1.
- With FillReqReady in cycle 1 and a matching response in cycle 2: ArrWrEn in cycle 3, REPLAY in cycle 4, IDLE hit (CoreRspValid) in cycle 5. Minimum miss penalty is 5 cycles.
- General case: a response in cycle N gives ArrWrEn in N+1 and a hit in N+3.
- Timeout: counted from the cycle after request acceptance. The re-request asserts FillReqValid in the cycle after the timeout.
- All outputs except the IDLE hit/miss decode (CoreRspValid, StallPc, PlruUpdate on hit) are pure state decodes or registers.

## Test plan
- Hit: TagHit=1, TagHitWay=5, CoreReqPc=0x100 → CoreRspValid=1, PlruUpdate=1, PlruWay=5, PlruMiss=0, StallPc=0, MissCount unchanged.
- Miss: CoreReqPc=0x1234, TagHit=0, PlruVictimWay=9, immediate ready, response data 0xA5.. in cycle 2 → FillReqAddr=0x1230 in cycle 1; ArrWrEn in cycle 3 with way 9, tag 0x0000123, data 0xA5..; PlruMiss=1; CoreRspValid in cycle 5; MissCount=1.
- Backpressure and a mismatched response: FillReqReady low for 3 cycles (FillReqAddr held stable), then a response for 0x2000 followed by one for 0x1230 → only the 0x1230 response is written.
- Timeout: FILL_TIMEOUT=4, no response → FillReqValid re-asserts after 4 wait cycles and RetryCount=1. A response on the exact timeout cycle → no retry.
- Reset in WAIT_FOR_IMEM, then a late response → no ArrWrEn, all outputs 0, state IDLE.
- 2^CNT_WIDTH+1 misses (CNT_WIDTH=4 build) → MissCount saturates at 0xF.

Source files
------------

// File: rtl/ifu_fill_ctrl.sv
// IFU instruction-cache miss controller.
// Reports hits, sequences line fills, writes the victim way and replays.
module ifu_fill_ctrl #(
  parameter int WAYS_NUM          = 16,
  parameter int CL_WIDTH          = 128,
  parameter int TAG_ADDRESS_WIDTH = 28,
  parameter int FILL_TIMEOUT      = 64,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          CoreReqValid,
  input  logic [31:0]                   CoreReqPc,
  input  logic                          TagHit,
  input  logic [$clog2(WAYS_NUM)-1:0]   TagHitWay,
  input  logic [$clog2(WAYS_NUM)-1:0]   PlruVictimWay,
  output logic                          CoreRspValid,
  output logic                          StallPc,
  output logic                          FillReqValid,
  output logic [31:0]                   FillReqAddr,
  input  logic                          FillReqReady,
  input  logic                          FillRspValid,
  input  logic [31:0]                   FillRspAddr,
  input  logic [CL_WIDTH-1:0]           FillRspData,
  output logic                          ArrWrEn,
  output logic [$clog2(WAYS_NUM)-1:0]   ArrWrWay,
  output logic [TAG_ADDRESS_WIDTH-1:0]  ArrWrTag,
  output logic [CL_WIDTH-1:0]           ArrWrData,
  output logic                          PlruUpdate,
  output logic [$clog2(WAYS_NUM)-1:0]   PlruWay,
  output logic                          PlruMiss,
  output logic [CNT_WIDTH-1:0]          MissCount,
  output logic [CNT_WIDTH-1:0]          RetryCount
);

  localparam int WAY_W = $clog2(WAYS_NUM);
  localparam int OFF_W = 32 - TAG_ADDRESS_WIDTH;
  localparam int TMR_W =
    (FILL_TIMEOUT > 1) ? $clog2(FILL_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'(FILL_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_REQ,
    WAIT_FOR_IMEM,
    FILL_DATA_ARR,
    REPLAY
  } state_t;

  state_t                       state;
  logic [TAG_ADDRESS_WIDTH-1:0] tag;
  logic [WAY_W-1:0]             victim;
  logic [CL_WIDTH-1:0]          line;
  logic [TMR_W-1:0]             timer;
  logic [CNT_WIDTH-1:0]         miss_count;
  logic [CNT_WIDTH-1:0]         retry_count;

  logic idle_st;
  logic fill_st;
  logic req_st;
  logic hit;
  logic miss;
  logic rsp_match;
  logic timed_out;

  // Low pc/address bits select a byte inside the line only.
  logic unused_low;
  assign unused_low =
    ^{CoreReqPc[OFF_W-1:0], FillRspAddr[OFF_W-1:0]};

  assign idle_st = (state == IDLE);
  assign fill_st = (state == FILL_DATA_ARR);
  assign req_st  = (state == SEND_REQ);

  // Hit/miss decode of the live fetch; masked while in reset.
  assign hit  = idle_st & ~Rst & CoreReqValid & TagHit;
  assign miss = idle_st & ~Rst & CoreReqValid & ~TagHit;

  assign rsp_match =
    FillRspValid &&
    (FillRspAddr[31:OFF_W] == tag);
  assign timed_out = (timer == TMR_LAST);

  assign CoreRspValid = hit;
  assign StallPc      = ~idle_st | miss;

  assign FillReqValid = req_st;
  assign FillReqAddr  =
    req_st ? {tag, {OFF_W{1'b0}}} : 32'd0;

  assign ArrWrEn   = fill_st;
  assign ArrWrWay  = fill_st ? victim : '0;
  assign ArrWrTag  = fill_st ? tag : '0;
  assign ArrWrData = fill_st ? line : '0;

  assign PlruUpdate = hit | fill_st;
  assign PlruMiss   = fill_st;

  // PLRU touch: victim on fill, hitting way on hit.
  always_comb begin
    PlruWay = '0;
    unique case (1'b1)
      fill_st: PlruWay = victim;
      hit:     PlruWay = TagHitWay;
      default: PlruWay = '0;
    endcase
  end

  assign MissCount  = miss_count;
  assign RetryCount = retry_count;

  // Miss sequencing, fill latching, timeout and statistics.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      tag         <= '0;
      victim      <= '0;
      line        <= '0;
      timer       <= '0;
      miss_count  <= '0;
      retry_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss) begin
            tag    <= CoreReqPc[31:OFF_W];
            victim <= PlruVictimWay;
            if (miss_count != '1)
              miss_count <= miss_count + CNT_ONE;
            state  <= SEND_REQ;
          end
        end
        SEND_REQ: begin
          if (FillReqReady) begin
            timer <= '0;
            state <= WAIT_FOR_IMEM;
          end
        end
        WAIT_FOR_IMEM: begin
          // A matching response beats the timeout.
          if (rsp_match) begin
            line  <= FillRspData;
            state <= FILL_DATA_ARR;
          end else if (timed_out) begin
            if (retry_count != '1)
              retry_count <= retry_count + CNT_ONE;
            state <= SEND_REQ;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        FILL_DATA_ARR: state <= REPLAY;
        REPLAY:        state <= IDLE;
        default:       state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fill_ctrl.sv
// Directed bench for ifu_fill_ctrl.
// Short timeout and narrow counters for reach.
module tb_ifu_fill_ctrl;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         CoreReqValid;
  logic [31:0]  CoreReqPc;
  logic         TagHit;
  logic [3:0]   TagHitWay;
  logic [3:0]   PlruVictimWay;
  logic         CoreRspValid;
  logic         StallPc;
  logic         FillReqValid;
  logic [31:0]  FillReqAddr;
  logic         FillReqReady;
  logic         FillRspValid;
  logic [31:0]  FillRspAddr;
  logic [127:0] FillRspData;
  logic         ArrWrEn;
  logic [3:0]   ArrWrWay;
  logic [27:0]  ArrWrTag;
  logic [127:0] ArrWrData;
  logic         PlruUpdate;
  logic [3:0]   PlruWay;
  logic         PlruMiss;
  logic [3:0]   MissCount;
  logic [3:0]   RetryCount;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  ifu_fill_ctrl #(
    .WAYS_NUM(16),
    .CL_WIDTH(128),
    .TAG_ADDRESS_WIDTH(28),
    .FILL_TIMEOUT(4),
    .CNT_WIDTH(4)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .CoreReqValid(CoreReqValid),
    .CoreReqPc(CoreReqPc),
    .TagHit(TagHit),
    .TagHitWay(TagHitWay),
    .PlruVictimWay(PlruVictimWay),
    .CoreRspValid(CoreRspValid),
    .StallPc(StallPc),
    .FillReqValid(FillReqValid),
    .FillReqAddr(FillReqAddr),
    .FillReqReady(FillReqReady),
    .FillRspValid(FillRspValid),
    .FillRspAddr(FillRspAddr),
    .FillRspData(FillRspData),
    .ArrWrEn(ArrWrEn),
    .ArrWrWay(ArrWrWay),
    .ArrWrTag(ArrWrTag),
    .ArrWrData(ArrWrData),
    .PlruUpdate(PlruUpdate),
    .PlruWay(PlruWay),
    .PlruMiss(PlruMiss),
    .MissCount(MissCount),
    .RetryCount(RetryCount)
  );

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet();
    CoreReqValid  = 1'b0;
    CoreReqPc     = 32'd0;
    TagHit        = 1'b0;
    TagHitWay     = 4'd0;
    PlruVictimWay = 4'd0;
    FillReqReady  = 1'b0;
    FillRspValid  = 1'b0;
    FillRspAddr   = 32'd0;
    FillRspData   = 128'd0;
  endtask

  // Complete miss with immediate ready and next-cycle response.
  task automatic do_fill(
    input logic [31:0] pc,
    input logic [3:0]  way
  );
    CoreReqValid  = 1'b1;
    CoreReqPc     = pc;
    TagHit        = 1'b0;
    PlruVictimWay = way;
    FillReqReady  = 1'b1;
    step();
    step();
    FillRspValid  = 1'b1;
    FillRspAddr   = {pc[31:4], 4'h0};
    FillRspData   = {4{pc}};
    step();
    FillRspValid  = 1'b0;
    CoreReqValid  = 1'b0;
    FillReqReady  = 1'b0;
    step();
    step();
  endtask

  logic [127:0] la5;
  logic [127:0] l11;
  logic [127:0] l22;
  logic [127:0] l33;

  initial begin
    la5 = {16{8'hA5}};
    l11 = {16{8'h11}};
    l22 = {16{8'h22}};
    l33 = {16{8'h33}};
    quiet();
    Rst = 1'b1;
    step();
    step();
    settle();
    check("rst_rsp", CoreRspValid, 1'b0);
    check("rst_stall", StallPc, 1'b0);
    check("rst_freq", FillReqValid, 1'b0);
    check("rst_faddr", FillReqAddr, 32'd0);
    check("rst_wren", ArrWrEn, 1'b0);
    check("rst_wrdata", ArrWrData, 128'd0);
    check("rst_plru", PlruUpdate, 1'b0);
    check("rst_miss", MissCount, 4'd0);
    check("rst_retry", RetryCount, 4'd0);
    Rst = 1'b0;
    step();

    // Hit: zero-cycle response.
    CoreReqValid = 1'b1;
    CoreReqPc    = 32'h100;
    TagHit       = 1'b1;
    TagHitWay    = 4'd5;
    settle();
    check("hit_rsp", CoreRspValid, 1'b1);
    check("hit_stall", StallPc, 1'b0);
    check("hit_plru", PlruUpdate, 1'b1);
    check("hit_way", PlruWay, 4'd5);
    check("hit_pmiss", PlruMiss, 1'b0);
    step();
    TagHitWay = 4'd12;
    settle();
    check("hit2_way", PlruWay, 4'd12);
    check("hit2_freq", FillReqValid, 1'b0);
    check("hit_cnt", MissCount, 4'd0);
    quiet();
    step();

    // Miss with immediate fill: cycle 0.
    CoreReqValid  = 1'b1;
    CoreReqPc     = 32'h1234;
    TagHit        = 1'b0;
    PlruVictimWay = 4'd9;
    FillReqReady  = 1'b1;
    settle();
    check("m0_stall", StallPc, 1'b1);
    check("m0_rsp", CoreRspValid, 1'b0);
    check("m0_freq", FillReqValid, 1'b0);
    step();
    PlruVictimWay = 4'd2;
    check("m1_freq", FillReqValid, 1'b1);
    check("m1_faddr", FillReqAddr, 32'h1230);
    check("m1_cnt", MissCount, 4'd1);
    step();
    FillRspValid = 1'b1;
    FillRspAddr  = 32'h1230;
    FillRspData  = la5;
    settle();
    check("m2_freq", FillReqValid, 1'b0);
    check("m2_wren", ArrWrEn, 1'b0);
    step();
    FillRspValid = 1'b0;
    settle();
    check("m3_wren", ArrWrEn, 1'b1);
    check("m3_way", ArrWrWay, 4'd9);
    check("m3_tag", ArrWrTag, 28'h0000123);
    check("m3_data", ArrWrData, la5);
    check("m3_plru", PlruUpdate, 1'b1);
    check("m3_pway", PlruWay, 4'd9);
    check("m3_pmiss", PlruMiss, 1'b1);
    step();
    TagHit    = 1'b1;
    TagHitWay = 4'd9;
    settle();
    check("m4_wren", ArrWrEn, 1'b0);
    check("m4_stall", StallPc, 1'b1);
    check("m4_rsp", CoreRspValid, 1'b0);
    step();
    check("m5_rsp", CoreRspValid, 1'b1);
    check("m5_stall", StallPc, 1'b0);
    check("m5_cnt", MissCount, 4'd1);
    quiet();
    step();

    // Backpressure then mismatched response.
    CoreReqValid  = 1'b1;
    CoreReqPc     = 32'h1230;
    PlruVictimWay = 4'd3;
    step();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp_freq", FillReqValid, 1'b1);
      check("bp_faddr", FillReqAddr, 32'h1230);
      step();
    end
    FillReqReady = 1'b1;
    settle();
    check("bp_acc", FillReqValid, 1'b1);
    step();
    FillReqReady = 1'b0;
    FillRspValid = 1'b1;
    FillRspAddr  = 32'h2000;
    FillRspData  = l11;
    step();
    check("bp_ign_wren", ArrWrEn, 1'b0);
    check("bp_ign_stall", StallPc, 1'b1);
    check("bp_ign_freq", FillReqValid, 1'b0);
    FillRspAddr = 32'h1230;
    FillRspData = l22;
    step();
    FillRspValid = 1'b0;
    settle();
    check("bp_wren", ArrWrEn, 1'b1);
    check("bp_way", ArrWrWay, 4'd3);
    check("bp_data", ArrWrData, l22);
    step();
    step();
    TagHit = 1'b1;
    settle();
    check("bp_hit", CoreRspValid, 1'b1);
    check("bp_cnt", MissCount, 4'd2);
    quiet();
    step();

    // Timeout retry, then a response on the timeout cycle.
    CoreReqValid = 1'b1;
    CoreReqPc    = 32'h4000;
    FillReqReady = 1'b1;
    step();
    check("to_c1", FillReqValid, 1'b1);
    step();
    FillReqReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("to_wait", FillReqValid, 1'b0);
      step();
    end
    check("to_req", FillReqValid, 1'b1);
    check("to_faddr", FillReqAddr, 32'h4000);
    check("to_retry", RetryCount, 4'd1);
    FillReqReady = 1'b1;
    step();
    FillReqReady = 1'b0;
    step();
    step();
    step();
    FillRspValid = 1'b1;
    FillRspAddr  = 32'h4000;
    FillRspData  = l33;
    step();
    FillRspValid = 1'b0;
    settle();
    check("toe_wren", ArrWrEn, 1'b1);
    check("toe_data", ArrWrData, l33);
    check("toe_freq", FillReqValid, 1'b0);
    check("toe_retry", RetryCount, 4'd1);
    check("toe_cnt", MissCount, 4'd3);
    step();
    step();
    quiet();
    step();

    // Reset while waiting for the fill, then a late response.
    CoreReqValid = 1'b1;
    CoreReqPc    = 32'h5000;
    FillReqReady = 1'b1;
    step();
    step();
    quiet();
    Rst = 1'b1;
    step();
    settle();
    check("rw_stall", StallPc, 1'b0);
    check("rw_wren", ArrWrEn, 1'b0);
    check("rw_freq", FillReqValid, 1'b0);
    check("rw_cnt", MissCount, 4'd0);
    Rst          = 1'b0;
    FillRspValid = 1'b1;
    FillRspAddr  = 32'h5000;
    FillRspData  = la5;
    step();
    FillRspValid = 1'b0;
    settle();
    check("late_wren", ArrWrEn, 1'b0);
    check("late_stall", StallPc, 1'b0);
    check("late_wrdata", ArrWrData, 128'd0);
    check("late_plru", PlruUpdate, 1'b0);
    step();

    // Saturate the 4-bit miss counter.
    for (int i = 0; i < 17; i++) begin
      do_fill(32'h8000 + 32'(i * 16), 4'(i));
      if (i == 13) check("sat_14", MissCount, 4'd14);
      if (i == 15) check("sat_16", MissCount, 4'hF);
    end
    check("sat_17", MissCount, 4'hF);
    check("sat_retry", RetryCount, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
